// File: rtl/ps2_mouse_device.sv
// Device-side PS/2 mouse endpoint: clocks the link, receives host commands with ACK, sends bytes.
// Optional build macro PS2_DEV_AUTO_ACK_EN adds an internal FA/FE reply after each received frame.
module ps2_mouse_device #(
  parameter int QTR = 2000,
  parameter int GAP = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  inout  wire        io_ps2Clk,
  inout  wire        io_ps2Data,
  input  logic [7:0] i_txData,
  input  logic       i_txValid,
  output logic       o_txReady,
  output logic [7:0] o_rxData,
  output logic       o_rxValid,
  output logic       o_rxErr,
  output logic       o_busy
);

  localparam int QW      = $clog2(QTR + 1);
  localparam int WAITMAX = (GAP > 2 * QTR) ? GAP : 2 * QTR;
  localparam int WW      = $clog2(WAITMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_RX, S_INHIBIT, S_GAP} state_t;

  state_t          r_state;
  logic            r_csMeta, r_cs, r_dsMeta, r_ds;
  logic            r_clkLow, r_dataLow;
  logic [QW-1:0]   r_qtrCnt, r_rtsCnt, r_txCnt;
  logic [1:0]      r_quarter;
  logic [3:0]      r_bitCnt;
  logic [WW-1:0]   r_waitCnt;
  logic [10:0]     r_txFrame;
  logic [7:0]      r_holdData;
  logic            r_pending;
  logic [9:0]      r_rxShift;
  logic [7:0]      r_rxData;
  logic            r_rxValid, r_rxErr, r_busy;

  logic            w_autoPend;
  logic [7:0]      w_autoByte;
  logic [7:0]      w_txByte;
  logic [10:0]     w_txFrame;
  logic            w_qtrEnd;
  logic            w_rxParOk;

`ifdef PS2_DEV_AUTO_ACK_EN
  logic            r_autoPend;
  logic [7:0]      r_autoByte;
  logic            r_txIsAuto;
  assign w_autoPend = r_autoPend;
  assign w_autoByte = r_autoByte;
`else
  assign w_autoPend = 1'b0;
  assign w_autoByte = 8'h00;
`endif

  // The internal reply always wins over the user byte in the holding register.
  assign w_txByte  = w_autoPend ? w_autoByte : r_holdData;
  assign w_txFrame = {1'b1, ~^w_txByte, w_txByte, 1'b0};
  assign w_qtrEnd  = (r_qtrCnt == QW'(QTR - 1));
  assign w_rxParOk = ^r_rxShift[8:0];

  assign io_ps2Clk  = r_clkLow  ? 1'b0 : 1'bz;
  assign io_ps2Data = r_dataLow ? 1'b0 : 1'bz;
  assign o_txReady  = ~r_pending;
  assign o_rxData   = r_rxData;
  assign o_rxValid  = r_rxValid;
  assign o_rxErr    = r_rxErr;
  assign o_busy     = r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_csMeta   <= 1'b1;
      r_cs       <= 1'b1;
      r_dsMeta   <= 1'b1;
      r_ds       <= 1'b1;
      r_clkLow   <= 1'b0;
      r_dataLow  <= 1'b0;
      r_qtrCnt   <= '0;
      r_rtsCnt   <= '0;
      r_txCnt    <= '0;
      r_quarter  <= 2'd0;
      r_bitCnt   <= 4'd0;
      r_waitCnt  <= '0;
      r_txFrame  <= '0;
      r_holdData <= 8'h00;
      r_pending  <= 1'b0;
      r_rxShift  <= '0;
      r_rxData   <= 8'h00;
      r_rxValid  <= 1'b0;
      r_rxErr    <= 1'b0;
      r_busy     <= 1'b0;
`ifdef PS2_DEV_AUTO_ACK_EN
      r_autoPend <= 1'b0;
      r_autoByte <= 8'h00;
      r_txIsAuto <= 1'b0;
`endif
    end else begin
      r_csMeta  <= io_ps2Clk;
      r_cs      <= r_csMeta;
      r_dsMeta  <= io_ps2Data;
      r_ds      <= r_dsMeta;
      r_rxValid <= 1'b0;
      r_rxErr   <= 1'b0;
      r_qtrCnt  <= w_qtrEnd ? '0 : r_qtrCnt + 1'b1;

      if (i_txValid && !r_pending) begin
        r_holdData <= i_txData;
        r_pending  <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_clkLow  <= 1'b0;
          r_dataLow <= 1'b0;
          if (r_cs && !r_ds) begin
            r_txCnt <= '0;
            if (r_rtsCnt == QW'(QTR - 1)) begin
              r_rtsCnt  <= '0;
              r_state   <= S_RX;
              r_busy    <= 1'b1;
              r_qtrCnt  <= '0;
              r_quarter <= 2'd0;
              r_bitCnt  <= 4'd0;
              r_clkLow  <= 1'b1;
            end else begin
              r_rtsCnt <= r_rtsCnt + 1'b1;
            end
          end else if (r_cs && r_ds && (r_pending || w_autoPend)) begin
            r_rtsCnt <= '0;
            if (r_txCnt == QW'(QTR - 1)) begin
              r_txCnt    <= '0;
              r_state    <= S_TX;
              r_busy     <= 1'b1;
              r_qtrCnt   <= '0;
              r_quarter  <= 2'd0;
              r_bitCnt   <= 4'd0;
              r_txFrame  <= w_txFrame;
              r_dataLow  <= ~w_txFrame[0];
`ifdef PS2_DEV_AUTO_ACK_EN
              r_txIsAuto <= w_autoPend;
`endif
            end else begin
              r_txCnt <= r_txCnt + 1'b1;
            end
          end else begin
            r_rtsCnt <= '0;
            r_txCnt  <= '0;
          end
        end

        // Bit cell: q0/q1 clock released with data set up, q2/q3 clock low.
        S_TX: begin
          if (w_qtrEnd) begin
            case (r_quarter)
              2'd0: r_quarter <= 2'd1;
              2'd1: begin
                if (!r_cs && r_bitCnt != 4'd10) begin
                  r_clkLow  <= 1'b0;
                  r_dataLow <= 1'b0;
                  r_waitCnt <= '0;
                  r_state   <= S_INHIBIT;
                end else begin
                  r_quarter <= 2'd2;
                  r_clkLow  <= 1'b1;
                end
              end
              2'd2: r_quarter <= 2'd3;
              default: begin
                r_clkLow  <= 1'b0;
                r_quarter <= 2'd0;
                if (r_bitCnt == 4'd10) begin
                  r_dataLow <= 1'b0;
                  r_waitCnt <= '0;
                  r_state   <= S_GAP;
`ifdef PS2_DEV_AUTO_ACK_EN
                  if (r_txIsAuto) r_autoPend <= 1'b0;
                  else            r_pending  <= 1'b0;
`else
                  r_pending <= 1'b0;
`endif
                end else begin
                  r_bitCnt  <= r_bitCnt + 4'd1;
                  r_txFrame <= {1'b0, r_txFrame[10:1]};
                  r_dataLow <= ~r_txFrame[1];
                end
              end
            endcase
          end
        end

        // Pulse: q0/q1 clock low, q2/q3 released; host data sampled at the end of q2.
        S_RX: begin
          if (w_qtrEnd) begin
            case (r_quarter)
              2'd0: r_quarter <= 2'd1;
              2'd1: begin
                r_quarter <= 2'd2;
                r_clkLow  <= 1'b0;
              end
              2'd2: begin
                r_quarter <= 2'd3;
                if (r_bitCnt != 4'd10) r_rxShift <= {r_ds, r_rxShift[9:1]};
              end
              default: begin
                r_quarter <= 2'd0;
                if (r_bitCnt == 4'd9) begin
                  if (!r_rxShift[9]) begin
                    r_rxErr   <= 1'b1;
                    r_waitCnt <= '0;
                    r_state   <= S_GAP;
                  end else begin
                    r_bitCnt  <= 4'd10;
                    r_clkLow  <= 1'b1;
                    r_dataLow <= 1'b1;
                  end
                end else if (r_bitCnt == 4'd10) begin
                  r_dataLow <= 1'b0;
                  r_waitCnt <= '0;
                  r_state   <= S_GAP;
                  if (w_rxParOk) begin
                    r_rxData  <= r_rxShift[7:0];
                    r_rxValid <= 1'b1;
                  end else begin
                    r_rxErr <= 1'b1;
                  end
`ifdef PS2_DEV_AUTO_ACK_EN
                  r_autoPend <= 1'b1;
                  r_autoByte <= w_rxParOk ? 8'hFA : 8'hFE;
`endif
                end else begin
                  r_bitCnt <= r_bitCnt + 4'd1;
                  r_clkLow <= 1'b1;
                end
              end
            endcase
          end
        end

        S_INHIBIT: begin
          if (!r_cs) begin
            r_waitCnt <= '0;
          end else if (r_waitCnt == WW'(2 * QTR - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end

        S_GAP: begin
          if (r_waitCnt == WW'(GAP - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_device.sv
// Scoreboard bench for ps2_mouse_device: host model on pulled-up lines, frame and rx monitors.
module tb_ps2_mouse_device;
  localparam int QTR  = 4;
  localparam int GAPC = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] txData = 8'h00;
  logic txValid = 1'b0;
  logic txReady, rxValid, rxErr, busy;
  logic [7:0] rxData;

  wire ps2Clk;
  wire ps2Data;
  pullup (ps2Clk);
  pullup (ps2Data);
  logic hostClkLow = 1'b0;
  logic hostDataLow = 1'b0;
  assign ps2Clk  = hostClkLow  ? 1'b0 : 1'bz;
  assign ps2Data = hostDataLow ? 1'b0 : 1'bz;

  ps2_mouse_device #(.QTR(QTR), .GAP(GAPC)) dut (
    .i_clk(clock), .i_rst(reset),
    .io_ps2Clk(ps2Clk), .io_ps2Data(ps2Data),
    .i_txData(txData), .i_txValid(txValid), .o_txReady(txReady),
    .o_rxData(rxData), .o_rxValid(rxValid), .o_rxErr(rxErr), .o_busy(busy)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int failCount = 0;
  logic [10:0] expTxQ[$];
  logic [8:0] expRxQ[$];
  int monBits = 0;
  int fallCnt = 0;
  int frameCnt = 0;
  logic [10:0] monFrame = '0;
  logic hostActive = 1'b0;
  logic watchReady = 1'b0;
  int readyViolations = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [10:0] frameOf(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // Host receiver: captures device frames on falling ps2 clock edges and scores them.
  initial begin
    logic monPrev;
    logic rxSeen;
    logic [8:0] e;
    monPrev = 1'b1;
    rxSeen = 1'b0;
    forever begin
      @(negedge clock);
      if (reset || hostActive) begin
        monBits = 0;
      end else if (monPrev && !ps2Clk) begin
        fallCnt++;
        monFrame[monBits] = ps2Data;
        monBits++;
        if (monBits == 11) begin
          monBits = 0;
          frameCnt++;
          if (expTxQ.size() == 0) checkOutput("tx_frame_unexpected", monFrame, 0);
          else checkOutput("tx_frame", monFrame, expTxQ.pop_front());
        end
      end
      monPrev = ps2Clk;
      if (watchReady && txReady) readyViolations++;
      if (rxSeen) begin
        checkOutput("rx_one_cycle", {rxValid, rxErr}, 2'b00);
        rxSeen = 1'b0;
      end else if (rxValid || rxErr) begin
        rxSeen = 1'b1;
        if (expRxQ.size() == 0) begin
          checkOutput("rx_unexpected", {rxValid, rxErr}, 2'b00);
        end else begin
          e = expRxQ.pop_front();
          checkOutput("rx_flags", {rxValid, rxErr}, e[8] ? 2'b01 : 2'b10);
          if (!e[8]) checkOutput("rx_data", rxData, e[7:0]);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitEdge(input logic rising, input int budget, output logic ok);
    logic prev;
    prev = ps2Clk;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (rising ? (!prev && ps2Clk) : (prev && !ps2Clk)) begin
        ok = 1'b1;
        break;
      end
      prev = ps2Clk;
    end
  endtask

  task automatic waitQuiet(input string tag);
    int quiet;
    logic ok;
    quiet = 0;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (!busy && expTxQ.size() == 0) quiet++;
      else quiet = 0;
      if (quiet >= 40) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(tag, ok, 1'b1);
  endtask

  task automatic loadTx(input logic [7:0] d);
    @(negedge clock);
    txData = d;
    txValid = 1'b1;
    @(negedge clock);
    txValid = 1'b0;
  endtask

  // Host-to-device frame: RTS, then one bit per device clock pulse, then look for the ACK.
  task automatic applyStimulus(input logic [7:0] d, input logic badParity, input logic badStop,
                               input logic preload, input logic [7:0] preByte);
    logic [9:0] bits;
    logic ok;
    logic allOk;
    bits = {~badStop, (~^d) ^ badParity, d};
    allOk = 1'b1;
    hostActive = 1'b1;
    hostClkLow = 1'b1;
    waitCycles(10);
    if (preload) loadTx(preByte);
    hostDataLow = 1'b1;
    waitCycles(2);
    expRxQ.push_back(badStop ? 9'h100 : {badParity, d});
`ifdef PS2_DEV_AUTO_ACK_EN
    if (!badStop) expTxQ.push_back(frameOf(badParity ? 8'hFE : 8'hFA));
`endif
    hostClkLow = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waitEdge(1'b0, 200, ok);
      allOk &= ok;
      hostDataLow = ~bits[i];
    end
    if (badStop) begin
      waitEdge(1'b1, 200, ok);
      allOk &= ok;
      waitCycles(6);
      hostDataLow = 1'b0;
    end else begin
      waitEdge(1'b0, 200, ok);
      allOk &= ok;
      waitCycles(2);
      checkOutput("rx_ack_low", ps2Data, 1'b0);
      waitEdge(1'b1, 200, ok);
      allOk &= ok;
    end
    checkOutput("rx_clock_pulses", allOk, 1'b1);
    hostActive = 1'b0;
  endtask

  initial begin
    #(2000000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ok;
    int n;
    int snap;

    waitCycles(5);
    checkOutput("reset_tx_ready", txReady, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rx_valid", rxValid, 1'b0);
    checkOutput("reset_rx_err", rxErr, 1'b0);
    checkOutput("reset_rx_data", rxData, 8'h00);
    checkOutput("reset_clk_released", ps2Clk, 1'b1);
    checkOutput("reset_data_released", ps2Data, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    waitCycles(10);
    checkOutput("idle_busy", busy, 1'b0);

    $display("[TB] test 1: device sends 08");
    expTxQ.push_back(11'b100_0001_0000);
    loadTx(8'h08);
    checkOutput("t1_ready_low", txReady, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (txReady) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("t1_ready_return", ok, 1'b1);
    checkOutput("t1_busy_in_gap", busy, 1'b1);
    n = 0;
    while (busy && n < GAPC + 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput("t1_gap_len", n, GAPC);
    waitQuiet("t1_quiet");

    $display("[TB] test 2: host sends F4 with good parity");
    applyStimulus(8'hF4, 1'b0, 1'b0, 1'b0, 8'h00);
    waitQuiet("t2_quiet");
    checkOutput("t2_rx_data_hold", rxData, 8'hF4);

    $display("[TB] test 3: host sends F4 with bad parity");
    applyStimulus(8'hF4, 1'b1, 1'b0, 1'b0, 8'h00);
    waitQuiet("t3_quiet");

    $display("[TB] stop-bit error frame");
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0, 8'h00);
    waitQuiet("stop_err_quiet");

    $display("[TB] test 4: host inhibit during 5A");
    expTxQ.push_back(frameOf(8'h5A));
    loadTx(8'h5A);
    watchReady = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (monBits == 4) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("t4_reach_bit", ok, 1'b1);
    hostActive = 1'b1;
    hostClkLow = 1'b1;
    waitCycles(5);
    loadTx(8'h33);
    waitCycles(30);
    checkOutput("t4_busy_inhibit", busy, 1'b1);
    checkOutput("t4_ready_low", txReady, 1'b0);
    hostClkLow = 1'b0;
    hostActive = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (expTxQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("t4_resent", ok, 1'b1);
    watchReady = 1'b0;
    checkOutput("t4_ready_held", readyViolations, 0);
    waitQuiet("t4_quiet");

    $display("[TB] test 5: RTS with pending byte");
    snap = frameCnt;
    applyStimulus(8'hE6, 1'b0, 1'b0, 1'b1, 8'hC3);
    checkOutput("t5_rx_first", frameCnt, snap);
    expTxQ.push_back(frameOf(8'hC3));
    waitQuiet("t5_quiet");

    $display("[TB] test 6: reset during a frame");
    loadTx(8'hA5);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (monBits == 3) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("t6_reach_bit", ok, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("t6_clk_released", ps2Clk, 1'b1);
    checkOutput("t6_data_released", ps2Data, 1'b1);
    checkOutput("t6_tx_ready", txReady, 1'b1);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_rx_data_cleared", rxData, 8'h00);
    waitCycles(3);
    reset = 1'b0;
    snap = fallCnt;
    waitCycles(400);
    checkOutput("t6_no_resume", fallCnt, snap);

    checkOutput("tx_queue_drained", expTxQ.size(), 0);
    checkOutput("rx_queue_drained", expRxQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
